booth_mult_seq: RTL and testbench
=================================

Name: booth_mult_seq

Overview:
- Self-contained sequential radix-2 Booth multiplier, parametrised in operand width.
- Integrates its own controller, operand capture and a start/busy/done handshake.
- Adds a per-operation signed/unsigned mode.
- Sits behind the lab ALU/top-level as a multi-cycle multiply unit. Operands are sampled only on an accepted start, never combinationally.

Parameters:
N, 4, operand width in bits (N >= 2); product width is 2N.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  request a multiply; accepted only when idle (state IDLE or DONE)
is_signed  input  1  1 = operands are two's complement, 0 = unsigned; captured with start
a  input  N  multiplicand; captured on accepted start
b  input  N  multiplier; captured on accepted start
busy  output  1  high while an operation is in progress (state CALC)
done  output  1  one-cycle pulse: result valid for the just-finished operation
result  output  2N  product; holds last completed value until the next completion

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, done=0, result=0, all internal registers 0. Reset mid-operation aborts it; no done is produced.
- Internal width W=N+1. Operands are extended to W bits: sign-extended if is_signed=1, zero-extended if 0.
- Internal registers:
  - M (W bits) = extended a.
  - Q (W bits) = extended b.
  - acc (W+1 bits, one guard bit).
  - q_m1 (1 bit).
  - cnt (ceil(log2(W+1)) bits).
- States: IDLE, CALC, DONE. busy = (state==CALC); done = (state==DONE).
- IDLE:
  - On an edge with start=1: capture M, Q and mode; acc=0, q_m1=0, cnt=0; go to CALC.
  - Otherwise remain in IDLE.
- CALC, one Booth iteration per clock:
  - Select on {Q[0],q_m1}: 01 -> acc+M; 10 -> acc-M; 00/11 -> acc unchanged. M is sign-extended to W+1 for this add.
  - Arithmetic shift right by 1 of {acc',Q,q_m1}; the acc MSB is replicated.
  - cnt increments.
  - The iteration with cnt==W-1 is the last one: on that edge go to DONE and load result = low 2N bits of the shifted {acc,Q}.
- Exactly W=N+1 iterations are run in both modes. This uniform count is correct for signed and unsigned: the extended product is exact, and the true product fits in 2N bits.
- DONE lasts one cycle.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation); the next state is CALC.
  - Otherwise the next state is IDLE.
- Latency: start sampled at edge k -> done high during the cycle after edge k+N+1 (N+1 cycles; 5 for N=4). Throughput: one result per N+2 cycles with back-to-back starts.
- start while busy is ignored. a, b and is_signed may change freely during CALC without affecting the result.
- result changes only on the edge entering DONE. It is stable in IDLE, CALC and DONE otherwise.
- Width rules:
  - Signed extreme: -2^(N-1) * -2^(N-1) = 2^(2N-2) is representable.
  - Unsigned extreme: (2^N-1)^2 < 2^(2N) is representable.
  - No overflow output.

Test Plan:
- N=4, is_signed=1, a=4'b1000 (-8), b=4'b1000 (-8), start 1 cycle -> busy high for 5 cycles, done pulse once, result=8'h40 (64).
- N=4, is_signed=1, a=7, b=4'b1101 (-3) -> result=8'hEB (-21). Then is_signed=0, a=4'hF, b=4'hF -> result=8'hE1 (225).
- N=4, is_signed=0, a=4'hF, b=0 -> result=8'h00. Then a=4'h9 (signed -7), b=4'h9, is_signed=1 -> result=8'h31 (49).
- Back-to-back: start held high continuously with changing operands -> a new operation is accepted in each DONE cycle. Starts pulsed during CALC with different a/b are ignored; results match the captured operands.
- Reset asserted mid-CALC (cycle 3) -> busy, done and result go to 0 immediately; no done pulse follows. A fresh start after release yields the correct product.
- N=8 instance, randomised 1000 ops in both modes vs reference model -> all results match. Latency is always 9 cycles; done is never asserted for more than 1 cycle.

Source files
------------

// File: rtl/booth_mult_seq_if.sv
// Handshake and operand bundle between a requester and booth_mult_seq.
interface booth_mult_seq_if #(
    parameter int N = 4
);
    logic             start;
    logic             is_signed;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   result;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, result
    );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with start/busy/done handshake and a
// per-operation signed/unsigned mode. Runs N+1 iterations on operands
// extended to N+1 bits, which makes one datapath exact for both modes.
module booth_mult_seq #(
    parameter int N = 4
) (
    input logic             clk,
    input logic             reset,
    booth_mult_seq_if.slave bus
);
    localparam int W  = N + 1;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_m;
    logic [W-1:0]   r_q;
    logic [W:0]     r_acc;
    logic           r_qm1;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic           r_done;
    logic [2*N-1:0] r_result;

    logic [W-1:0]   w_a_ext;
    logic [W-1:0]   w_b_ext;
    logic [W:0]     w_m_ext;
    logic [W:0]     w_sum;
    logic [W:0]     w_acc_sh;
    logic [W-1:0]   w_q_sh;
    logic           w_accept;
    logic           w_last;

    // The mode only affects operand extension, so it is folded into M/Q at
    // capture time instead of being held in its own register.
    assign w_a_ext  = bus.is_signed ? {bus.a[N-1], bus.a} : {1'b0, bus.a};
    assign w_b_ext  = bus.is_signed ? {bus.b[N-1], bus.b} : {1'b0, bus.b};
    assign w_accept = bus.start && (r_state != S_CALC);
    assign w_last   = (r_cnt == CW'(W - 1));

    // Booth add/subtract selection followed by the arithmetic right shift.
    always_comb begin
        w_m_ext = {r_m[W-1], r_m};
        w_sum   = r_acc;
        case ({r_q[0], r_qm1})
            2'b01:   w_sum = r_acc + w_m_ext;
            2'b10:   w_sum = r_acc - w_m_ext;
            default: w_sum = r_acc;
        endcase
        w_acc_sh = {w_sum[W], w_sum[W:1]};
        w_q_sh   = {w_sum[0], r_q[W-1:1]};
    end

    // Controller, datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_m      <= '0;
            r_q      <= '0;
            r_acc    <= '0;
            r_qm1    <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_m     <= w_a_ext;
                        r_q     <= w_b_ext;
                        r_acc   <= '0;
                        r_qm1   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_CALC;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    r_done <= 1'b0;
                end
                S_CALC: begin
                    r_acc <= w_acc_sh;
                    r_q   <= w_q_sh;
                    r_qm1 <= r_q[0];
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        // The low 2N bits of the shifted {acc,Q} hold the product.
                        r_result <= {w_acc_sh[N-2:0], w_q_sh};
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: an N=4 and an N=8 instance share clock and reset.
// A timeline model predicts busy/done/result every cycle; directed operations
// also carry hand-computed products and latencies.
module tb_booth_mult_seq;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    booth_mult_seq_if #(.N(4)) bus4 ();
    booth_mult_seq_if #(.N(8)) bus8 ();

    booth_mult_seq #(.N(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));
    booth_mult_seq #(.N(8)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8));

    logic        ist [2];
    logic        isg [2];
    logic [7:0]  ia  [2];
    logic [7:0]  ib  [2];
    logic        o_busy [2];
    logic        o_done [2];
    logic [15:0] o_res  [2];

    assign bus4.start     = ist[0];
    assign bus4.is_signed = isg[0];
    assign bus4.a         = ia[0][3:0];
    assign bus4.b         = ib[0][3:0];
    assign bus8.start     = ist[1];
    assign bus8.is_signed = isg[1];
    assign bus8.a         = ia[1];
    assign bus8.b         = ib[1];
    assign o_busy[0] = bus4.busy;
    assign o_done[0] = bus4.done;
    assign o_res[0]  = {8'h00, bus4.result};
    assign o_busy[1] = bus8.busy;
    assign o_done[1] = bus8.done;
    assign o_res[1]  = bus8.result;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nn(input int i);
        return (i == 0) ? 4 : 8;
    endfunction

    // Cycles from accepted start to the done cycle.
    function automatic int nw(input int i);
        return nn(i) + 1;
    endfunction

    // Plain integer product of two n-bit operands, truncated to 2n bits.
    function automatic logic [15:0] ref_prod(input int n, input logic s,
                                             input logic [7:0] a, input logic [7:0] b);
        longint mask_n, mask_p, x, y, p;
        mask_n = (longint'(1) << n) - 1;
        mask_p = (longint'(1) << (2 * n)) - 1;
        x = longint'(a) & mask_n;
        y = longint'(b) & mask_n;
        if (s && a[n-1]) x = x - (longint'(1) << n);
        if (s && b[n-1]) y = y - (longint'(1) << n);
        p = x * y;
        return 16'(p & mask_p);
    endfunction

    // Timeline model: an accepted start makes the unit busy for N+1 cycles,
    // then done for one cycle with the product of the captured operands.
    int          m_left [2];
    logic        m_done [2];
    logic [15:0] m_res  [2];
    logic [15:0] m_pend [2];

    always @(posedge clk or negedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_left[i] <= 0;
                m_done[i] <= 1'b0;
                m_res[i]  <= '0;
                m_pend[i] <= '0;
            end else begin
                m_done[i] <= 1'b0;
                if (m_left[i] > 0) begin
                    m_left[i] <= m_left[i] - 1;
                    if (m_left[i] == 1) begin
                        m_done[i] <= 1'b1;
                        m_res[i]  <= m_pend[i];
                    end
                end else if (ist[i]) begin
                    m_left[i] <= nw(i);
                    m_pend[i] <= ref_prod(nn(i), isg[i], ia[i], ib[i]);
                end
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d_busy", i), 16'(o_busy[i]), 16'(m_left[i] > 0));
            check($sformatf("u%0d_done", i), 16'(o_done[i]), 16'(m_done[i]));
            check($sformatf("u%0d_result", i), o_res[i], m_res[i]);
        end
    end

    task automatic run_op(input int i, input logic s, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input string nm);
        int k;
        k = 0;
        @(negedge clk);
        ist[i] = 1'b1; isg[i] = s; ia[i] = a; ib[i] = b;
        @(negedge clk);
        ist[i] = 1'b0; isg[i] = ~s; ia[i] = ~a; ib[i] = ~b;
        while (!o_done[i] && k < 30) begin
            @(negedge clk);
            k++;
        end
        check({nm, "_done"}, 16'(o_done[i]), 16'd1);
        check(nm, o_res[i], exp);
        check({nm, "_lat"}, 16'(k), 16'(nw(i)));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        for (int i = 0; i < 2; i++) begin
            ist[i] = 1'b0; isg[i] = 1'b0; ia[i] = '0; ib[i] = '0;
        end
        repeat (3) @(negedge clk);
        check("reset_busy", 16'(o_busy[0]), 16'd0);
        check("reset_done", 16'(o_done[0]), 16'd0);
        check("reset_result", o_res[0], 16'd0);
        reset = 1'b1;

        // Model anchors.
        check("model_s_m8m8", ref_prod(4, 1'b1, 8'h08, 8'h08), 16'h0040);
        check("model_u_ff", ref_prod(4, 1'b0, 8'h0F, 8'h0F), 16'h00E1);
        check("model_s8_7f80", ref_prod(8, 1'b1, 8'h7F, 8'h80), 16'hC080);

        // N=4 directed products.
        run_op(0, 1'b1, 8'h08, 8'h08, 16'h0040, "s_m8_m8");
        run_op(0, 1'b1, 8'h07, 8'h0D, 16'h00EB, "s_7_m3");
        run_op(0, 1'b0, 8'h0F, 8'h0F, 16'h00E1, "u_15_15");
        run_op(0, 1'b0, 8'h0F, 8'h00, 16'h0000, "u_15_0");
        run_op(0, 1'b1, 8'h09, 8'h09, 16'h0031, "s_m7_m7");

        // Start pulsed during CALC with other operands is ignored.
        @(negedge clk);
        ist[0] = 1'b1; isg[0] = 1'b1; ia[0] = 8'h03; ib[0] = 8'h05;
        @(negedge clk);
        ist[0] = 1'b0;
        @(negedge clk);
        ist[0] = 1'b1; ia[0] = 8'h07; ib[0] = 8'h07;
        @(negedge clk);
        ist[0] = 1'b0;
        cnt = 0;
        while (!o_done[0] && cnt < 30) begin
            @(negedge clk);
            cnt++;
        end
        check("ignore_start_result", o_res[0], 16'h000F);
        repeat (3) @(negedge clk);

        // Back-to-back: start held high, operands changing every cycle.
        cnt = 0;
        for (int j = 0; j < 26; j++) begin
            @(negedge clk);
            if (o_done[0]) cnt++;
            ist[0] = (j < 18);
            ia[0]  = 8'(j * 3 + 1);
            ib[0]  = 8'(j * 5 + 2);
            isg[0] = j[0];
        end
        check("b2b_done_count", 16'(cnt), 16'd3);

        // Reset in the middle of CALC aborts the operation.
        @(negedge clk);
        ist[0] = 1'b1; isg[0] = 1'b0; ia[0] = 8'h05; ib[0] = 8'h06;
        @(negedge clk);
        ist[0] = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midreset_busy", 16'(o_busy[0]), 16'd0);
        check("midreset_done", 16'(o_done[0]), 16'd0);
        check("midreset_result", o_res[0], 16'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_done[0]) cnt++;
        end
        check("midreset_no_done", 16'(cnt), 16'd0);
        run_op(0, 1'b0, 8'h05, 8'h06, 16'h001E, "after_reset");

        // N=8 directed extremes.
        run_op(1, 1'b1, 8'h80, 8'h80, 16'h4000, "s8_m128_m128");
        run_op(1, 1'b0, 8'hFF, 8'hFF, 16'hFE01, "u8_255_255");
        run_op(1, 1'b1, 8'h7F, 8'h80, 16'hC080, "s8_127_m128");

        // N=8 random traffic in both modes, checked by the model each cycle.
        for (int j = 0; j < 12000; j++) begin
            @(negedge clk);
            ist[1] = ($urandom_range(0, 3) != 0);
            isg[1] = 1'($urandom_range(0, 1));
            ia[1]  = 8'($urandom);
            ib[1]  = 8'($urandom);
        end
        @(negedge clk);
        ist[1] = 1'b0;
        repeat (12) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
